// File: rtl/xgmii_pkg.sv
// Shared constants and types for the XGMII to 64b/66b transmit encoder.
package xgmii_pkg;

    localparam int unsigned LANES   = 8;
    localparam int unsigned BLOCK_W = 66;

    localparam logic [7:0] CHAR_IDLE  = 8'h07;
    localparam logic [7:0] CHAR_START = 8'hFB;
    localparam logic [7:0] CHAR_TERM  = 8'hFD;
    localparam logic [7:0] CHAR_ERROR = 8'hFE;

    localparam logic [6:0] CODE_IDLE  = 7'h00;
    localparam logic [6:0] CODE_ERROR = 7'h1E;

    localparam logic [7:0] TYPE_C  = 8'h1E;
    localparam logic [7:0] TYPE_S0 = 8'h78;
    localparam logic [7:0] TYPE_S4 = 8'h33;
    // Terminate block type indexed by the lane holding TERM
    localparam logic [7:0] TYPE_T [LANES] = '{8'h87, 8'h99, 8'hAA, 8'hB4,
                                              8'hCC, 8'hD2, 8'hE1, 8'hFF};

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    localparam logic [BLOCK_W-1:0] EBLOCK     = {{8{CODE_ERROR}}, TYPE_C, SYNC_CTRL};
    localparam logic [BLOCK_W-1:0] IDLE_BLOCK = {56'd0, TYPE_C, SYNC_CTRL};

    typedef enum logic [2:0] {
        TX_INIT = 3'd0,
        TX_C    = 3'd1,
        TX_D    = 3'd2,
        TX_T    = 3'd3,
        TX_E    = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        BLK_C = 3'd0,
        BLK_S = 3'd1,
        BLK_D = 3'd2,
        BLK_T = 3'd3,
        BLK_E = 3'd4
    } blk_class_t;

endpackage

// File: rtl/xgmii_block_classifier.sv
// Combinational classification of one XGMII word into C, S, D, T or E.
module xgmii_block_classifier
    import xgmii_pkg::*;
(
    input  logic [63:0] data_in,
    input  logic [7:0]  ctrl_in,
    output logic [2:0]  blk_class,
    output logic [2:0]  t_lane,
    output logic [2:0]  start_lane
);

    logic [7:0] lane [LANES];
    logic       all_ce;
    logic       t_ok;
    logic       t_found;
    blk_class_t cls;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign lane[i] = data_in[8*i +: 8];
    end

    always_comb begin
        all_ce  = 1'b1;
        t_ok    = 1'b0;
        t_found = 1'b0;
        t_lane  = 3'd0;
        for (int i = 0; i < LANES; i++) begin
            if (lane[i] != CHAR_IDLE && lane[i] != CHAR_ERROR) all_ce = 1'b0;
        end
        // TERM at lane k: control bits k..7, lanes after k idle
        for (int k = 0; k < LANES; k++) begin
            t_ok = (ctrl_in == 8'(8'hFF << k)) && (lane[k] == CHAR_TERM);
            for (int j = 0; j < LANES; j++) begin
                if (j > k && lane[j] != CHAR_IDLE) t_ok = 1'b0;
            end
            if (t_ok) begin
                t_found = 1'b1;
                t_lane  = 3'(k);
            end
        end
    end

    always_comb begin
        cls        = BLK_E;
        start_lane = 3'd0;
        if (ctrl_in == 8'h00) begin
            cls = BLK_D;
        end else if (ctrl_in == 8'hFF && all_ce) begin
            cls = BLK_C;
        end else if (ctrl_in == 8'h01 && lane[0] == CHAR_START) begin
            cls = BLK_S;
        end else if (ctrl_in == 8'h1F && lane[0] == CHAR_IDLE && lane[1] == CHAR_IDLE &&
                     lane[2] == CHAR_IDLE && lane[3] == CHAR_IDLE && lane[4] == CHAR_START) begin
            cls        = BLK_S;
            start_lane = 3'd4;
        end else if (t_found) begin
            cls = BLK_T;
        end
    end

    assign blk_class = cls;

endmodule

// File: rtl/xgmii_64b66b_encoder.sv
// Clause 49 transmit encoder: one registered 66-bit block per clock, with
// invalid sequences replaced by error blocks and counted.
module xgmii_64b66b_encoder
    import xgmii_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned ERR_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     data_in,
    input  logic [DATA_WIDTH/8-1:0]   ctrl_in,
    output logic [BLOCK_W-1:0]        block_out,
    output logic [2:0]                tx_state,
    output logic [ERR_CNT_WIDTH-1:0]  err_count
);

    if (DATA_WIDTH != 64) begin : g_bad_width
        $error("xgmii_64b66b_encoder: DATA_WIDTH must be 64");
    end

    logic [2:0]         cls_raw;
    logic [2:0]         t_lane;
    logic [2:0]         start_lane;
    blk_class_t         cls;
    tx_state_t          state;
    tx_state_t          next_state;
    logic               accept;
    logic [55:0]        c_codes;
    logic [55:0]        t_data;
    logic [BLOCK_W-1:0] fmt_block;
    logic [BLOCK_W-1:0] next_block;

    xgmii_block_classifier u_classifier (
        .data_in    (data_in),
        .ctrl_in    (ctrl_in),
        .blk_class  (cls_raw),
        .t_lane     (t_lane),
        .start_lane (start_lane)
    );

    assign cls = blk_class_t'(cls_raw);

    // Block formatter: encoding of the current word assuming it is legal here
    always_comb begin
        c_codes = '0;
        t_data  = '0;
        for (int i = 0; i < LANES; i++) begin
            c_codes[7*i +: 7] = (data_in[8*i +: 8] == CHAR_ERROR) ? CODE_ERROR : CODE_IDLE;
        end
        for (int i = 0; i < LANES - 1; i++) begin
            if (3'(i) < t_lane) t_data[8*i +: 8] = data_in[8*i +: 8];
        end
        case (cls)
            BLK_D:   fmt_block = {data_in, SYNC_DATA};
            BLK_C:   fmt_block = {c_codes, TYPE_C, SYNC_CTRL};
            BLK_S:   fmt_block = (start_lane == 3'd0) ?
                                 {data_in[63:8], TYPE_S0, SYNC_CTRL} :
                                 {data_in[63:40], 4'h0, {4{CODE_IDLE}}, TYPE_S4, SYNC_CTRL};
            BLK_T:   fmt_block = {t_data, TYPE_T[t_lane], SYNC_CTRL};
            default: fmt_block = EBLOCK;
        endcase
    end

    // Legal successors: C/S outside a packet, D/T inside, anything but E after an error
    always_comb begin
        case (state)
            TX_D:    accept = (cls == BLK_D) || (cls == BLK_T);
            TX_E:    accept = (cls != BLK_E);
            default: accept = (cls == BLK_C) || (cls == BLK_S);
        endcase
        next_state = TX_E;
        next_block = EBLOCK;
        if (accept) begin
            next_block = fmt_block;
            case (cls)
                BLK_C:   next_state = TX_C;
                BLK_S:   next_state = TX_D;
                BLK_D:   next_state = TX_D;
                BLK_T:   next_state = TX_T;
                default: next_state = TX_E;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= TX_INIT;
            block_out <= IDLE_BLOCK;
            err_count <= '0;
        end else begin
            state     <= next_state;
            block_out <= next_block;
            // An all-ERROR control word encodes identically to EBLOCK and counts too
            if (next_block == EBLOCK && err_count != '1) begin
                err_count <= err_count + ERR_CNT_WIDTH'(1);
            end
        end
    end

    assign tx_state = state;

endmodule

// File: tb/tb_xgmii_64b66b_encoder.sv
// Scoreboard bench for xgmii_64b66b_encoder using hand-computed block values.
module tb_xgmii_64b66b_encoder;

    localparam logic [65:0] B_IDLE = 66'h7A;
    localparam logic [65:0] B_EBLK = {{8{7'h1E}}, 8'h1E, 2'b10};
    localparam logic [63:0] W_IDLE = 64'h0707070707070707;
    localparam logic [63:0] W_AERR = 64'hFEFEFEFEFEFEFEFE;
    localparam logic [63:0] W_S0   = 64'hD5555555555555FB;
    localparam logic [63:0] W_D1   = 64'h0123456789ABCDEF;
    localparam logic [63:0] W_D2   = 64'hFEDCBA9876543210;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] data_in;
    logic [7:0]  ctrl_in;
    logic [65:0] block_out;
    logic [2:0]  tx_state;
    logic [15:0] err_count;

    typedef struct {
        string       tag;
        logic [65:0] blk;
        logic [2:0]  st;
        logic [15:0] err;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_err  = '0;

    always #5 clk = ~clk;

    xgmii_64b66b_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .ctrl_in   (ctrl_in),
        .block_out (block_out),
        .tx_state  (tx_state),
        .err_count (err_count)
    );

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Apply a word now and queue what must appear after the next rising edge
    task automatic drive(input string tag, input logic [63:0] d, input logic [7:0] c,
                         input logic [65:0] eb, input logic [2:0] es, input bit inc);
        exp_t e;
        data_in = d;
        ctrl_in = c;
        if (inc && exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
        e.tag = tag;
        e.blk = eb;
        e.st  = es;
        e.err = exp_err;
        q.push_back(e);
    endtask

    task automatic send(input string tag, input logic [63:0] d, input logic [7:0] c,
                        input logic [65:0] eb, input logic [2:0] es, input bit inc);
        @(negedge clk);
        drive(tag, d, c, eb, es, inc);
    endtask

    // Monitor: one block per clock, compared shortly after each rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check({e.tag, ".block"}, block_out, e.blk);
                check({e.tag, ".state"}, 66'(tx_state), 66'(e.st));
                check({e.tag, ".err"}, 66'(err_count), 66'(e.err));
            end
        end
    end

    initial begin
        rst     = 1'b1;
        data_in = W_IDLE;
        ctrl_in = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        check("reset.block", block_out, B_IDLE);
        check("reset.state", 66'(tx_state), 66'd0);
        check("reset.err", 66'(err_count), 66'd0);

        @(negedge clk);
        rst = 1'b0;
        drive("idle1", W_IDLE, 8'hFF, B_IDLE, 3'd1, 0);
        send("idle2", W_IDLE, 8'hFF, B_IDLE, 3'd1, 0);
        send("idle3", W_IDLE, 8'hFF, B_IDLE, 3'd1, 0);

        send("s0", W_S0, 8'h01, {64'hD555555555555578, 2'b10}, 3'd2, 0);
        send("d1", W_D1, 8'h00, {W_D1, 2'b01}, 3'd2, 0);
        send("d2", W_D2, 8'h00, {W_D2, 2'b01}, 3'd2, 0);
        send("t3", 64'h07070707FD332211, 8'hF8, {64'h00000000332211B4, 2'b10}, 3'd3, 0);
        send("idle4", W_IDLE, 8'hFF, B_IDLE, 3'd1, 0);

        send("s4", 64'hCCBBAAFB07070707, 8'h1F, {64'hCCBBAA0000000033, 2'b10}, 3'd2, 0);
        send("t0", 64'h07070707070707FD, 8'hFF, {64'h0000000000000087, 2'b10}, 3'd3, 0);
        send("s0b", W_S0, 8'h01, {64'hD555555555555578, 2'b10}, 3'd2, 0);
        send("t7", 64'hFD66554433221100, 8'h80, {64'h66554433221100FF, 2'b10}, 3'd3, 0);
        send("idle5", W_IDLE, 8'hFF, B_IDLE, 3'd1, 0);

        send("c_err0", 64'h07070707070707FE, 8'hFF, {64'h0000000000001E1E, 2'b10}, 3'd1, 0);
        send("c_allerr", W_AERR, 8'hFF, B_EBLK, 3'd1, 1);

        send("ss_first", W_S0, 8'h01, {64'hD555555555555578, 2'b10}, 3'd2, 0);
        send("ss_second", W_S0, 8'h01, B_EBLK, 3'd4, 1);
        send("e_to_d", W_D1, 8'h00, {W_D1, 2'b01}, 3'd2, 0);
        send("d_idle", W_IDLE, 8'hFF, B_EBLK, 3'd4, 1);
        send("e_to_c", W_IDLE, 8'hFF, B_IDLE, 3'd1, 0);

        send("pre_rst_s", W_S0, 8'h01, {64'hD555555555555578, 2'b10}, 3'd2, 0);
        send("pre_rst_d", W_D1, 8'h00, {W_D1, 2'b01}, 3'd2, 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst.block", block_out, B_IDLE);
        check("async_rst.state", 66'(tx_state), 66'd0);
        check("async_rst.err", 66'(err_count), 66'd0);
        exp_err = '0;

        @(negedge clk);
        rst = 1'b0;
        drive("first_d", W_D1, 8'h00, B_EBLK, 3'd4, 1);
        send("after_first_d", W_IDLE, 8'hFF, B_IDLE, 3'd1, 0);

        for (int i = 0; i < 65541; i++) begin
            send("sat", 64'h0, 8'hAA, B_EBLK, 3'd4, 1);
        end
        send("sat_allerr", W_AERR, 8'hFF, B_EBLK, 3'd1, 1);
        send("sat_idle", W_IDLE, 8'hFF, B_IDLE, 3'd1, 0);

        repeat (3) @(posedge clk);
        #2;
        check("drain", 66'(q.size()), 66'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/xgmii_64b66b_encoder.md
# xgmii_64b66b_encoder

Transmit-side 64b/66b encoder sitting directly downstream of `gmii_generator`. It consumes the 64-bit data / 8-bit control character stream and produces one 66-bit block per clock, following the IEEE 802.3 Clause 49 TX state machine. Invalid sequences are replaced by error blocks and counted. Its output feeds the scrambler/gearbox; `gmii_checker` remains attached to the encoder's input.

## Interface
- `DATA_WIDTH`, default 64: input data width; only 64 is legal (elaboration error otherwise).
- `ERR_CNT_WIDTH`, default 16: width of the saturating error counter.
- `clk  in  1`: the single clock; all logic is rising-edge.
- `rst  in  1`: reset; asynchronous, active-high.
- `data_in  in  DATA_WIDTH`: 8 lanes; lane k is `[8k+7:8k]`, lane 0 is first on the wire.
- `ctrl_in  in  DATA_WIDTH/8`: bit k=1 marks lane k as a control character.
- `block_out  out  66`: `[1:0]` = sync header; `[65:2]` = payload. For control blocks the type byte is at `[9:2]`.
- `tx_state  out  3`: current encoder state (debug).
- `err_count  out  ERR_CNT_WIDTH`: count of error blocks emitted; saturates at all-ones.

## Operation
- Characters: IDLE 0x07 (7-bit code 0x00), START 0xFB, TERM 0xFD, ERROR 0xFE (7-bit code 0x1E).
- Each input word is classified as exactly one of C, S, D, T or E.
  - D: `ctrl_in`=0x00. Sync 2'b01, payload = `data_in`.
  - C: `ctrl_in`=0xFF, every lane IDLE or ERROR. Sync 2'b10, type 0x1E, then eight 7-bit codes.
  - S: `ctrl_in`=0x01, lane0=START. Type 0x78, then lanes 1..7.
  - S also: `ctrl_in`=0x1F, lanes 0-3 IDLE, lane4=START. Type 0x33, codes 0 for lanes 0-3, 4 zero bits, then lanes 5..7.
  - T at lane k (k=0..7): `ctrl_in` bits k..7 set and bits 0..k-1 clear, lane k=TERM, lanes k+1..7 IDLE.
    - Type for k=0..7: 0x87, 0x99, 0xAA, 0xB4, 0xCC, 0xD2, 0xE1, 0xFF.
    - Payload: data lanes 0..k-1, then zero-padded, then 7-bit codes 0x00 for lanes k+1..7.
  - E: anything else.
- States: INIT(0), C(1), D(2), T(3), E(4).
- Transitions from INIT, C and T:
  - C → state C, emit C block.
  - S → state D, emit S block.
  - D, T or E → state E, emit error block.
- Transitions from D:
  - D → stay D, emit data block.
  - T → state T, emit T block.
  - C, S or E → state E, emit error block.
- Transitions from E:
  - C → state C; S → state D; D → state D; T → state T. Each emits its own block.
  - E → stay E, emit error block.
- Error block (EBLOCK): sync 2'b10, type 0x1E, all eight codes 0x1E.
- `err_count` increments by 1 on every cycle that emits an EBLOCK. This includes input classified C whose lanes are all ERROR, since the encoding is identical. It holds at max.

## Timing
- Latency is 1 cycle: the input sampled at edge n appears on `block_out` after edge n; `tx_state` updates on the same edge.
- Output is fully registered; there is no handshake, and one block is emitted per clock.
- Reset values:
  - `block_out` = 66'h7A (idle C block: type 0x1E, sync 2'b10).
  - `tx_state` = INIT.
  - `err_count` = 0.
- Reset asserted mid-packet: outputs return to reset values immediately (asynchronously).
- First word after reset release: classified from INIT, so D or T yields EBLOCK.
- Counter saturation and an error on the same cycle: the value stays at all-ones.

## Structure
- Package `xgmii_pkg` holds:
  - character constants;
  - 7-bit code constants;
  - block type constants, including the T-type array indexed by k;
  - sync header constants;
  - the `tx_state_t` enum;
  - the `blk_class_t` enum {C, S, D, T, E}.
- Sub-module `xgmii_block_classifier` is combinational. It takes `data_in`/`ctrl_in` and outputs the class, the T lane index and the start lane.
- The top level holds the state register, block formatter and counter.

## Test plan
- Reset, then 3 cycles of all-IDLE (`ctrl_in`=0xFF, data 0x0707…07) → `block_out`=66'h7A each cycle, `tx_state`=C, `err_count`=0.
- IDLE, then S0 (`data_in`=64'hD5555555555555FB, `ctrl_in`=0x01), then D ×2, then T at lane 3 (lanes 0-2 data, lane3=0xFD, `ctrl_in`=0xF8), then IDLE → types 0x1E, 0x78, data blocks with sync 01, 0xB4, 0x1E, each 1 cycle late; `err_count`=0.
- S at lane 4 (`ctrl_in`=0x1F) → type 0x33, lanes 5-7 data in the payload MSBs.
- D immediately after reset → EBLOCK, `tx_state`=E, `err_count`=1; a subsequent IDLE → C block, state C.
- S then S (no T) → second output is EBLOCK, `err_count`+1; force 2^16+5 errors → `err_count`=16'hFFFF.
- Assert `rst` asynchronously mid-D-state → `block_out`=66'h7A and `tx_state`=INIT before the next edge.
